// File: rtl/spi_channel_scheduler.sv
// spi_channel_scheduler: round-robin sharing of one SPI transaction engine among NUM_REQ requesters.
// Define SPI_SCHED_TIMEOUT_EN to add a WAIT-state watchdog of TIMEOUT_CYCLES clocks.
module spi_channel_scheduler #(
   parameter int NUM_REQ        = 4,
   parameter int DATA_W         = 24,
   parameter int RX_W           = 16,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                      S_AXI_ACLK,
   input  logic                      S_AXI_ARESET,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_tx,
   input  logic [NUM_REQ*5-1:0]      req_len,
   output logic                      eng_start,
   output logic [DATA_W-1:0]         eng_tx,
   output logic [4:0]                eng_len,
   input  logic                      eng_busy,
   input  logic                      eng_done,
   input  logic [RX_W-1:0]           eng_rx,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [RX_W-1:0]           rsp_data,
   output logic                      timeout_err
);
   localparam int IW = $clog2(NUM_REQ);
   typedef enum logic [2:0] {IDLE, GRANT, START, WAIT, RESP} state_e;
   state_e state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d, idx_q, idx_d, win;
   logic found, to_hit;
   logic [DATA_W-1:0] win_tx, eng_tx_q, eng_tx_d;
   logic [4:0] win_len, eng_len_q, eng_len_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d, rsp_valid_q, rsp_valid_d;
   logic [RX_W-1:0] rsp_data_q, rsp_data_d;
   logic eng_start_q, eng_start_d;
   // First requesting index at or after ptr, wrapping.
   always_comb begin
      found   = 1'b0;
      win     = '0;
      win_tx  = '0;
      win_len = '0;
      for (int k = 0; k < NUM_REQ; k++)
         if (!found && req[(int'(ptr_q) + k) % NUM_REQ]) begin
            found = 1'b1;
            win   = IW'((int'(ptr_q) + k) % NUM_REQ);
         end
      for (int i = 0; i < NUM_REQ; i++)
         if (IW'(i) == win) begin
            win_tx  = req_tx[i*DATA_W +: DATA_W];
            win_len = req_len[i*5 +: 5];
         end
   end
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET)
      if (S_AXI_ARESET) state_q <= IDLE;
      else state_q <= state_d;
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    state_d = |req ? GRANT : IDLE;
         GRANT:   state_d = found ? START : IDLE;
         START:   state_d = ~|eng_len_q ? RESP : eng_busy ? START : WAIT;
         WAIT:    state_d = (eng_done || to_hit) ? RESP : WAIT;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      idx_d       = idx_q;
      ptr_d       = ptr_q;
      eng_tx_d    = eng_tx_q;
      eng_len_d   = eng_len_q;
      gnt_d       = gnt_q;
      rsp_data_d  = rsp_data_q;
      eng_start_d = 1'b0;
      rsp_valid_d = '0;
      case (state_q)
         GRANT: if (found) begin
            idx_d     = win;
            eng_tx_d  = win_tx;
            eng_len_d = win_len;
            gnt_d     = NUM_REQ'(1) << win;
         end
         START: begin
            eng_start_d = |eng_len_q && !eng_busy;
            rsp_valid_d = ~|eng_len_q ? NUM_REQ'(1) << idx_q : '0;
            rsp_data_d  = ~|eng_len_q ? '0 : rsp_data_q;
         end
         WAIT: begin
            rsp_valid_d = (eng_done || to_hit) ? NUM_REQ'(1) << idx_q : '0;
            rsp_data_d  = eng_done ? eng_rx : to_hit ? '1 : rsp_data_q;
         end
         RESP: begin
            gnt_d = '0;
            ptr_d = idx_q == IW'(NUM_REQ - 1) ? '0 : idx_q + 1'b1;
         end
         default: ;
      endcase
   end
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET)
      if (S_AXI_ARESET) begin
         idx_q       <= '0;
         ptr_q       <= '0;
         eng_tx_q    <= '0;
         eng_len_q   <= '0;
         gnt_q       <= '0;
         rsp_data_q  <= '0;
         eng_start_q <= 1'b0;
         rsp_valid_q <= '0;
      end else begin
         idx_q       <= idx_d;
         ptr_q       <= ptr_d;
         eng_tx_q    <= eng_tx_d;
         eng_len_q   <= eng_len_d;
         gnt_q       <= gnt_d;
         rsp_data_q  <= rsp_data_d;
         eng_start_q <= eng_start_d;
         rsp_valid_q <= rsp_valid_d;
      end
`ifdef SPI_SCHED_TIMEOUT_EN
   logic [15:0] cnt_q;
   logic to_q;
   assign to_hit = state_q == WAIT && cnt_q == 16'(TIMEOUT_CYCLES);
   // Counter sits at zero outside WAIT, so every WAIT entry starts a fresh count.
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET)
      if (S_AXI_ARESET) begin
         cnt_q <= '0;
         to_q  <= 1'b0;
      end else begin
         cnt_q <= state_q == WAIT ? cnt_q + 16'd1 : '0;
         to_q  <= to_hit && !eng_done;
      end
   assign timeout_err = to_q;
`else
   assign to_hit      = 1'b0;
   assign timeout_err = 1'b0;
`endif
   assign eng_start = eng_start_q;
   assign eng_tx    = eng_tx_q;
   assign eng_len   = eng_len_q;
   assign gnt       = gnt_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
endmodule

// File: doc/spi_channel_scheduler.md
SPI_CHANNEL_SCHEDULER -- requirements
Module: spi_channel_scheduler

Interface
REQ-001 Parameter NUM_REQ, 4, number of requesters sharing one SPI transaction engine (2..8).
REQ-002 Parameter DATA_W, 24, transmit word width (SDI frame).
REQ-003 Parameter RX_W, 16, receive word width (SDO frame).
REQ-004 Parameter TIMEOUT_CYCLES, 4096, WAIT-state watchdog limit in clocks (used only with SPI_SCHED_TIMEOUT_EN).
REQ-005 S_AXI_ACLK  in  1  single clock; all logic on rising edge.
REQ-006 S_AXI_ARESET  in  1  reset, asynchronous, active-high.
REQ-007 req  in  NUM_REQ  per-requester transaction request, level, held until own rsp_valid.
REQ-008 req_tx  in  NUM_REQ*DATA_W  per-requester transmit word, requester i at bits [i*DATA_W +: DATA_W].
REQ-009 req_len  in  NUM_REQ*5  per-requester bit count (cycle_max), requester i at [i*5 +: 5].
REQ-010 eng_start  out  1  one-cycle start pulse to SPI engine.
REQ-011 eng_tx  out  DATA_W  transmit word to engine, stable from START until RESP.
REQ-012 eng_len  out  5  bit count to engine, stable from START until RESP.
REQ-013 eng_busy  in  1  engine transaction in progress.
REQ-014 eng_done  in  1  one-cycle engine completion pulse.
REQ-015 eng_rx  in  RX_W  engine receive word, valid with eng_done.
REQ-016 gnt  out  NUM_REQ  one-hot index of requester currently owning the engine, zero in IDLE.
REQ-017 rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse to owning requester.
REQ-018 rsp_data  out  RX_W  response word, valid while any rsp_valid bit high.
REQ-019 timeout_err  out  1  one-cycle pulse coincident with a timed-out response.

Function
REQ-020 FSM states: IDLE, GRANT, START, WAIT, RESP; all outputs registered.
REQ-021 IDLE: if any req bit high, go GRANT; else stay.
REQ-022 GRANT: select winner by round-robin starting at pointer ptr; latch index, req_tx, req_len; assert gnt; go START.
REQ-023 START: if latched len == 0, skip engine, go RESP with rsp_data = 0; else if eng_busy low, pulse eng_start one cycle and go WAIT; if eng_busy high, hold in START without pulsing.
REQ-024 WAIT: on eng_done, capture eng_rx into rsp_data and go RESP; eng_done in any other state is ignored.
REQ-025 RESP: rsp_valid[index] high one cycle, gnt cleared, ptr <= index+1 modulo NUM_REQ, go IDLE.
REQ-026 Latency: req rising in IDLE -> eng_start 3 cycles later with eng_busy low; eng_done -> rsp_valid 1 cycle later.
REQ-027 Simultaneous requests: lowest index at or above ptr wins, wrapping past NUM_REQ-1 to 0; no requester starves beyond NUM_REQ-1 transactions.
REQ-028 req dropped after GRANT: transaction completes, response still issued.
REQ-029 Requester asserting req during its own RESP cycle is eligible only from the next IDLE.

Reset
REQ-030 S_AXI_ARESET asserted, any state: FSM -> IDLE, ptr -> 0, gnt, rsp_valid, eng_start, timeout_err -> 0, eng_tx, eng_len, rsp_data -> 0, immediately without clock.
REQ-031 Reset mid-WAIT: no response issued; late eng_done after reset release ignored.

Configuration
REQ-032 SPI_SCHED_TIMEOUT_EN defined: 16-bit counter clears on WAIT entry; reaching TIMEOUT_CYCLES in WAIT forces RESP with rsp_data all-ones and timeout_err pulsed with rsp_valid.
REQ-033 SPI_SCHED_TIMEOUT_EN undefined: no counter, WAIT is unbounded, timeout_err tied 0.

Verification
REQ-034 req=4'b0001, req_len[0]=24, tx=24'hA5A5A5, engine done after 40 cycles with eng_rx=16'h1234 -> eng_start 3 cycles after req, eng_tx=24'hA5A5A5, rsp_valid=4'b0001, rsp_data=16'h1234.
REQ-035 req=4'b1111 held continuously, ptr=0 -> service order 0,1,2,3,0; gnt one-hot throughout.
REQ-036 req=4'b0100, req_len[2]=0 -> no eng_start, rsp_valid=4'b0100 with rsp_data=0 two cycles after GRANT.
REQ-037 eng_busy held high 10 cycles during START -> eng_start pulses once, on first cycle eng_busy low.
REQ-038 Reset asserted mid-WAIT, then eng_done -> no rsp_valid, gnt=0, next grant goes to requester 0.
REQ-039 SPI_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=16, no eng_done -> rsp_data=16'hFFFF, timeout_err and rsp_valid pulse 17 cycles after eng_start.
